// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, instruction class enum, opcode/funct
// constants, ALU operation codes, datapath mux select codes and the
// decoded-instruction record latched by the controller in ID.
package multi_cycle_ctrl_pkg;

  // FSM states; the encoding is visible on the state output.
  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_e;

  // Instruction classes; each class owns one path through the FSM.
  typedef enum logic [3:0] {
    CL_R   = 4'd0,
    CL_LW  = 4'd1,
    CL_SW  = 4'd2,
    CL_BR  = 4'd3,
    CL_J   = 4'd4,
    CL_JAL = 4'd5,
    CL_JR  = 4'd6,
    CL_IMM = 4'd7,
    CL_ILL = 4'd8
  } cls_e;

  // Primary opcodes (instruction bits 31:26).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Function codes for OP_RTYPE (instruction bits 5:0).
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operation codes.
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4;
  localparam logic [4:0] ALU_SLL = 5'd5;
  localparam logic [4:0] ALU_SRL = 5'd6;

  // ALU operand A select.
  localparam logic [1:0] SRCA_RS    = 2'd0;
  localparam logic [1:0] SRCA_C16   = 2'd1;  // constant 16, lui shifts imm by it
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  // ALU operand B select.
  localparam logic [1:0] SRCB_RT  = 2'd0;
  localparam logic [1:0] SRCB_IMM = 2'd1;

  // Register-file destination select.
  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_RA = 2'd2;

  // Register-file write-data select.
  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;

  // PC source select.
  localparam logic [1:0] PCS_PC4 = 2'd0;
  localparam logic [1:0] PCS_BR  = 2'd1;
  localparam logic [1:0] PCS_JMP = 2'd2;
  localparam logic [1:0] PCS_RS  = 2'd3;

  // Everything the controller needs to remember about the instruction
  // after ID.
  typedef struct packed {
    cls_e       cls;
    logic       is_bne;     // BR class: branch on zero==0 instead of zero==1
    logic [4:0] alu_ctrl;
    logic       ext_ctrl;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
  } dec_t;

  // Decode record used while no instruction is in flight.
  localparam dec_t DEC_ILL = '{
    cls:       CL_ILL,
    is_bne:    1'b0,
    alu_ctrl:  ALU_ADD,
    ext_ctrl:  1'b1,
    alu_src_a: SRCA_RS,
    alu_src_b: SRCB_RT
  };

endpackage

// File: rtl/multi_cycle_ctrl_instr_decode.sv
// Combinational instruction decoder: op/funct -> class and ALU controls.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the inputs.
//
// Ports: op_i, funct_i (instruction fields) -> cls_o, alu_ctrl_o,
// ext_ctrl_o, alu_src_a_o, alu_src_b_o, is_bne_o.
module instr_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output cls_e       cls_o,
  output logic [4:0] alu_ctrl_o,
  output logic       ext_ctrl_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       is_bne_o
);

  always_comb begin
    cls_o       = CL_ILL;
    alu_ctrl_o  = ALU_ADD;
    ext_ctrl_o  = 1'b1;
    alu_src_a_o = SRCA_RS;
    alu_src_b_o = SRCB_RT;
    is_bne_o    = 1'b0;

    case (op_i)
      OP_RTYPE: begin
        // Unknown funct values fall through as CL_ILL.
        case (funct_i)
          FN_ADD: begin cls_o = CL_R; alu_ctrl_o = ALU_ADD; end
          FN_SUB: begin cls_o = CL_R; alu_ctrl_o = ALU_SUB; end
          FN_AND: begin cls_o = CL_R; alu_ctrl_o = ALU_AND; end
          FN_OR:  begin cls_o = CL_R; alu_ctrl_o = ALU_OR;  end
          FN_SLT: begin cls_o = CL_R; alu_ctrl_o = ALU_SLT; end
          FN_SLL: begin
            cls_o       = CL_R;
            alu_ctrl_o  = ALU_SLL;
            alu_src_a_o = SRCA_SHAMT;
          end
          FN_SRL: begin
            cls_o       = CL_R;
            alu_ctrl_o  = ALU_SRL;
            alu_src_a_o = SRCA_SHAMT;
          end
          FN_JR:  cls_o = CL_JR;
          default: cls_o = CL_ILL;
        endcase
      end
      OP_J:   cls_o = CL_J;
      OP_JAL: cls_o = CL_JAL;
      OP_BEQ: begin cls_o = CL_BR; alu_ctrl_o = ALU_SUB; end
      OP_BNE: begin cls_o = CL_BR; alu_ctrl_o = ALU_SUB; is_bne_o = 1'b1; end
      OP_ADDI: begin
        cls_o       = CL_IMM;
        alu_ctrl_o  = ALU_ADD;
        alu_src_b_o = SRCB_IMM;
      end
      OP_ORI: begin
        cls_o       = CL_IMM;
        alu_ctrl_o  = ALU_OR;
        alu_src_b_o = SRCB_IMM;
        ext_ctrl_o  = 1'b0;
      end
      OP_LUI: begin
        // imm << 16 is done as a shift by the constant-16 operand.
        cls_o       = CL_IMM;
        alu_ctrl_o  = ALU_SLL;
        alu_src_a_o = SRCA_C16;
        alu_src_b_o = SRCB_IMM;
      end
      OP_LW: begin
        cls_o       = CL_LW;
        alu_ctrl_o  = ALU_ADD;
        alu_src_b_o = SRCB_IMM;
      end
      OP_SW: begin
        cls_o       = CL_SW;
        alu_ctrl_o  = ALU_ADD;
        alu_src_b_o = SRCB_IMM;
      end
      default: cls_o = CL_ILL;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset controller: IF/ID/EX/MEM/WB FSM plus retire counter.
// Latency: 2-5 cycles per instruction, plus memory wait cycles in IF and MEM.
// Backpressure: IF and MEM stall in place while mem_rdy is low.
//
// Ports:
//   clk, rst (async, active low)         clock and reset
//   op, funct                            instruction register fields
//   zero, mem_rdy                        ALU equality flag, memory handshake
//   mem_req, mem_wr, ir_wr, pc_wr, reg_wr  request / write enables
//   alu_ctrl, reg_dst, alu_src_a, alu_src_b, mem2reg, pc_src, ext_ctrl
//                                        datapath controls
//   state, illegal, retired              FSM state, bad-opcode pulse, count
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_rdy,
  output logic        mem_req,
  output logic        mem_wr,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic        reg_wr,
  output logic [4:0]  alu_ctrl,
  output logic [1:0]  reg_dst,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  mem2reg,
  output logic [1:0]  pc_src,
  output logic        ext_ctrl,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  state_e      state_q, state_d;
  dec_t        dec_q;          // instruction record latched at the end of ID
  dec_t        dec_live;       // decoder output for the current IR contents
  dec_t        cur;            // record the outputs are decoded from
  logic        run_q;          // low during reset and the cycle after release
  logic        retire_now;
  logic [31:0] retired_q;

  cls_e        dec_cls;
  logic [4:0]  dec_alu_ctrl;
  logic        dec_ext_ctrl;
  logic [1:0]  dec_alu_src_a;
  logic [1:0]  dec_alu_src_b;
  logic        dec_is_bne;

  instr_decode u_decode (
    .op_i        (op),
    .funct_i     (funct),
    .cls_o       (dec_cls),
    .alu_ctrl_o  (dec_alu_ctrl),
    .ext_ctrl_o  (dec_ext_ctrl),
    .alu_src_a_o (dec_alu_src_a),
    .alu_src_b_o (dec_alu_src_b),
    .is_bne_o    (dec_is_bne)
  );

  assign dec_live = '{
    cls:       dec_cls,
    is_bne:    dec_is_bne,
    alu_ctrl:  dec_alu_ctrl,
    ext_ctrl:  dec_ext_ctrl,
    alu_src_a: dec_alu_src_a,
    alu_src_b: dec_alu_src_b
  };

  // The IR is loaded at the end of IF, so during ID the decoder already sees
  // the new instruction; later states use the copy captured in ID.
  assign cur = (state_q == ST_ID) ? dec_live : dec_q;

  // Controls are decoded from state and the class record. They are not
  // registered because IF/MEM must react to mem_rdy and EX to zero within
  // the same cycle. run_q is a flop with async clear, so every enable drops
  // as soon as rst is asserted.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    reg_wr     = 1'b0;
    illegal    = 1'b0;
    retire_now = 1'b0;
    reg_dst    = RDST_RT;
    mem2reg    = M2R_ALU;
    pc_src     = PCS_PC4;
    alu_ctrl   = cur.alu_ctrl;
    alu_src_a  = cur.alu_src_a;
    alu_src_b  = cur.alu_src_b;
    ext_ctrl   = cur.ext_ctrl;

    if (run_q) begin
      case (state_q)
        ST_IF: begin
          mem_req = 1'b1;
          if (mem_rdy) begin
            ir_wr   = 1'b1;
            pc_wr   = 1'b1;
            pc_src  = PCS_PC4;
            state_d = ST_ID;
          end
        end
        ST_ID: begin
          case (cur.cls)
            CL_J: begin
              pc_wr      = 1'b1;
              pc_src     = PCS_JMP;
              retire_now = 1'b1;
              state_d    = ST_IF;
            end
            CL_JAL: begin
              pc_wr      = 1'b1;
              pc_src     = PCS_JMP;
              reg_wr     = 1'b1;
              reg_dst    = RDST_RA;
              mem2reg    = M2R_PC4;
              retire_now = 1'b1;
              state_d    = ST_IF;
            end
            CL_ILL: begin
              illegal = 1'b1;
              state_d = ST_IF;
            end
            default: state_d = ST_EX;
          endcase
        end
        ST_EX: begin
          case (cur.cls)
            CL_BR: begin
              // beq takes on zero=1, bne on zero=0.
              if (zero ^ cur.is_bne) begin
                pc_wr  = 1'b1;
                pc_src = PCS_BR;
              end
              retire_now = 1'b1;
              state_d    = ST_IF;
            end
            CL_JR: begin
              pc_wr      = 1'b1;
              pc_src     = PCS_RS;
              retire_now = 1'b1;
              state_d    = ST_IF;
            end
            CL_LW, CL_SW:  state_d = ST_MEM;
            CL_R, CL_IMM:  state_d = ST_WB;
            default:       state_d = ST_IF;
          endcase
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_wr  = (cur.cls == CL_SW);
          if (mem_rdy) begin
            if (cur.cls == CL_LW) begin
              state_d = ST_WB;
            end else begin
              retire_now = 1'b1;
              state_d    = ST_IF;
            end
          end
        end
        ST_WB: begin
          reg_wr     = 1'b1;
          reg_dst    = (cur.cls == CL_R)  ? RDST_RD : RDST_RT;
          mem2reg    = (cur.cls == CL_LW) ? M2R_MEM : M2R_ALU;
          retire_now = 1'b1;
          state_d    = ST_IF;
        end
        default: state_d = ST_IF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IF;
      run_q     <= 1'b0;
      dec_q     <= DEC_ILL;
      retired_q <= '0;
    end else begin
      // First real IF cycle starts on the edge after reset release.
      run_q   <= 1'b1;
      state_q <= state_d;
      if (run_q && (state_q == ST_ID)) begin
        dec_q <= dec_live;
      end
      if (retire_now) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_rdy;
  logic        mem_req, mem_wr, ir_wr, pc_wr, reg_wr, ext_ctrl, illegal;
  logic [4:0]  alu_ctrl;
  logic [1:0]  reg_dst, alu_src_a, alu_src_b, mem2reg, pc_src;
  logic [2:0]  state;
  logic [31:0] retired;

  always #5 clk = ~clk;

  multi_cycle_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .mem_rdy   (mem_rdy),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .ir_wr     (ir_wr),
    .pc_wr     (pc_wr),
    .reg_wr    (reg_wr),
    .alu_ctrl  (alu_ctrl),
    .reg_dst   (reg_dst),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .mem2reg   (mem2reg),
    .pc_src    (pc_src),
    .ext_ctrl  (ext_ctrl),
    .state     (state),
    .illegal   (illegal),
    .retired   (retired)
  );

  localparam int P_R   = 0;
  localparam int P_IMM = 1;
  localparam int P_LW  = 2;
  localparam int P_SW  = 3;
  localparam int P_BRT = 4;  // branch taken
  localparam int P_BRN = 5;  // branch not taken
  localparam int P_JR  = 6;
  localparam int P_J   = 7;
  localparam int P_JAL = 8;
  localparam int P_ILL = 9;
  localparam int NVEC  = 22;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         path;
    int         ifw;      // IF cycles with mem_rdy low
    int         mw;       // MEM cycles with mem_rdy low
    logic       chk_alu;
    logic [4:0] alu;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic       ext;
  } vec_t;

  typedef struct {
    logic        rdy;     // mem_rdy to drive this cycle
    logic [14:0] sig;     // expected control signature
    logic        is_ex;
  } step_t;

  vec_t        vt[NVEC];
  step_t       exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] retired_exp;

  // Selects are only meaningful while their write enable is high.
  function automatic logic [14:0] mk(input logic [2:0] st, input logic req,
                                     input logic wr, input logic irw,
                                     input logic pcw, input logic rgw,
                                     input logic ill, input logic [1:0] pcs,
                                     input logic [1:0] rd, input logic [1:0] m2r);
    return {st, req, wr, irw, pcw, rgw, ill,
            pcw ? pcs : 2'b00, rgw ? rd : 2'b00, rgw ? m2r : 2'b00};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic rdy, input logic [14:0] sig, input logic is_ex);
    step_t s;
    s.rdy   = rdy;
    s.sig   = sig;
    s.is_ex = is_ex;
    exp_q.push_back(s);
  endtask

  function automatic logic dc();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle trace of one instruction.
  task automatic build(input vec_t v);
    logic sw;
    sw = (v.path == P_SW);
    for (int i = 0; i < v.ifw; i++)
      push(1'b0, mk(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0), 1'b0);
    push(1'b1, mk(3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0), 1'b0);
    case (v.path)
      P_J:   push(dc(), mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0), 1'b0);
      P_JAL: push(dc(), mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 2'd2, 2'd2), 1'b0);
      P_ILL: push(dc(), mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0), 1'b0);
      default: begin
        push(dc(), mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0), 1'b0);
        if (v.path == P_BRT)
          push(dc(), mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0), 1'b1);
        else if (v.path == P_JR)
          push(dc(), mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0), 1'b1);
        else
          push(dc(), mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0), 1'b1);
        if (v.path == P_LW || v.path == P_SW) begin
          for (int i = 0; i < v.mw; i++)
            push(1'b0, mk(3'd3, 1'b1, sw, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0), 1'b0);
          push(1'b1, mk(3'd3, 1'b1, sw, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0), 1'b0);
        end
        if (v.path == P_R)
          push(dc(), mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 2'd0), 1'b0);
        else if (v.path == P_IMM)
          push(dc(), mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0), 1'b0);
        else if (v.path == P_LW)
          push(dc(), mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd1), 1'b0);
      end
    endcase
  endtask

  // Called at a negedge in IF; returns at the negedge of the next IF.
  task automatic run(input int idx);
    vec_t  v;
    step_t s;
    int    cyc;
    v     = vt[idx];
    op    = v.op;
    funct = v.funct;
    zero  = v.zero;
    build(v);
    cyc = 0;
    while (exp_q.size() > 0) begin
      s       = exp_q.pop_front();
      mem_rdy = s.rdy;
      #1;
      check($sformatf("v%0d_cyc%0d_ctl", idx, cyc),
            64'(mk(state, mem_req, mem_wr, ir_wr, pc_wr, reg_wr, illegal,
                   pc_src, reg_dst, mem2reg)),
            64'(s.sig));
      if (s.is_ex && v.chk_alu)
        check($sformatf("v%0d_alu", idx),
              64'({alu_ctrl, alu_src_a, alu_src_b, ext_ctrl}),
              64'({v.alu, v.srca, v.srcb, v.ext}));
      @(negedge clk);
      cyc++;
    end
    if (v.path != P_ILL) retired_exp = retired_exp + 32'd1;
    #1;
    check($sformatf("v%0d_retired", idx), 64'(retired), 64'(retired_exp));
  endtask

  initial begin
    //          op     funct  z     path   ifw mw chk   alu   srca  srcb  ext
    vt[0]  = '{6'h00, 6'h20, 1'b0, P_R,   0, 0, 1'b1, 5'd0, 2'd0, 2'd0, 1'b1}; // add
    vt[1]  = '{6'h00, 6'h22, 1'b0, P_R,   2, 0, 1'b1, 5'd1, 2'd0, 2'd0, 1'b1}; // sub
    vt[2]  = '{6'h00, 6'h24, 1'b0, P_R,   0, 0, 1'b1, 5'd2, 2'd0, 2'd0, 1'b1}; // and
    vt[3]  = '{6'h00, 6'h25, 1'b1, P_R,   1, 0, 1'b1, 5'd3, 2'd0, 2'd0, 1'b1}; // or
    vt[4]  = '{6'h00, 6'h2A, 1'b0, P_R,   0, 0, 1'b1, 5'd4, 2'd0, 2'd0, 1'b1}; // slt
    vt[5]  = '{6'h00, 6'h00, 1'b0, P_R,   0, 0, 1'b1, 5'd5, 2'd2, 2'd0, 1'b1}; // sll
    vt[6]  = '{6'h00, 6'h02, 1'b0, P_R,   0, 0, 1'b1, 5'd6, 2'd2, 2'd0, 1'b1}; // srl
    vt[7]  = '{6'h08, 6'h00, 1'b0, P_IMM, 0, 0, 1'b1, 5'd0, 2'd0, 2'd1, 1'b1}; // addi
    vt[8]  = '{6'h0D, 6'h3F, 1'b0, P_IMM, 0, 0, 1'b1, 5'd3, 2'd0, 2'd1, 1'b0}; // ori
    vt[9]  = '{6'h0F, 6'h00, 1'b0, P_IMM, 0, 0, 1'b1, 5'd5, 2'd1, 2'd1, 1'b1}; // lui
    vt[10] = '{6'h23, 6'h00, 1'b0, P_LW,  0, 3, 1'b1, 5'd0, 2'd0, 2'd1, 1'b1}; // lw, 3 waits
    vt[11] = '{6'h2B, 6'h00, 1'b0, P_SW,  1, 0, 1'b1, 5'd0, 2'd0, 2'd1, 1'b1}; // sw
    vt[12] = '{6'h04, 6'h00, 1'b1, P_BRT, 0, 0, 1'b1, 5'd1, 2'd0, 2'd0, 1'b1}; // beq taken
    vt[13] = '{6'h04, 6'h00, 1'b0, P_BRN, 0, 0, 1'b1, 5'd1, 2'd0, 2'd0, 1'b1}; // beq not
    vt[14] = '{6'h05, 6'h00, 1'b0, P_BRT, 0, 0, 1'b1, 5'd1, 2'd0, 2'd0, 1'b1}; // bne taken
    vt[15] = '{6'h05, 6'h00, 1'b1, P_BRN, 0, 0, 1'b1, 5'd1, 2'd0, 2'd0, 1'b1}; // bne not
    vt[16] = '{6'h02, 6'h00, 1'b0, P_J,   0, 0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b1}; // j
    vt[17] = '{6'h03, 6'h00, 1'b0, P_JAL, 0, 0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b1}; // jal
    vt[18] = '{6'h00, 6'h08, 1'b0, P_JR,  0, 0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b1}; // jr
    vt[19] = '{6'h3F, 6'h00, 1'b0, P_ILL, 0, 0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b1}; // bad op
    vt[20] = '{6'h00, 6'h3F, 1'b0, P_ILL, 0, 0, 1'b0, 5'd0, 2'd0, 2'd0, 1'b1}; // bad funct
    vt[21] = '{6'h23, 6'h00, 1'b0, P_LW,  1, 0, 1'b1, 5'd0, 2'd0, 2'd1, 1'b1}; // lw, no wait

    retired_exp = 32'd0;

    // Reset: mem_rdy high must not move the FSM or raise mem_req.
    rst     = 1'b0;
    op      = 6'h00;
    funct   = 6'h20;
    zero    = 1'b0;
    mem_rdy = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_state", 64'(state), 64'd0);
    check("rst_enables", 64'({mem_req, mem_wr, ir_wr, pc_wr, reg_wr, illegal}), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    rst = 1'b1;
    #1;
    check("release_gap_req", 64'({mem_req, ir_wr}), 64'd0);
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) run(i);

    // Reset asserted while a store sits in MEM.
    op      = 6'h2B;
    funct   = 6'h00;
    mem_rdy = 1'b1;
    @(negedge clk);            // ID
    mem_rdy = 1'b0;
    @(negedge clk);            // EX
    @(negedge clk);            // MEM, memory not ready
    #1;
    check("sw_mem_before_rst", 64'({state, mem_req, mem_wr}), 64'({3'd3, 1'b1, 1'b1}));
    rst = 1'b0;
    #1;
    check("sw_rst_mem_wr", 64'({mem_req, mem_wr}), 64'd0);
    check("sw_rst_state", 64'(state), 64'd0);
    check("sw_rst_retired", 64'(retired), 64'd0);
    retired_exp = 32'd0;
    mem_rdy = 1'b1;
    @(negedge clk);
    #1;
    check("sw_rst_held", 64'({state, mem_req, mem_wr, pc_wr, reg_wr}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    run(0);                    // add after reset: retired 0 -> 1

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
